// File: rtl/data_memory_ws.sv
// Clocked byte-addressable data memory with programmable wait states and a Req/Ready handshake.
// The access executes on the clock edge that enters RESP; DataRd and the error flags stay registered until the next access.
module data_memory_ws #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataWr,
  input  logic              DMWr,
  input  logic [2:0]        DMCtrl,
  output logic [31:0]       DataRd,
  output logic              Ready,
  output logic              Busy,
  output logic              Misaligned,
  output logic              OutOfRange
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic              w_accept;
  logic              w_exec;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic [2:0]        r_ctrl;

  logic [31:0]       r_data_rd;
  logic              r_mis;
  logic              r_oor;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] w_src_addr;
  logic [31:0]       w_src_wdata;
  logic              w_src_wr;
  logic [2:0]        w_src_ctrl;
  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_oor;
  logic              w_ctrl_ok;
  logic              w_mis_raw;
  logic              w_ok;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_cur_word;
  logic [31:0]       w_new_word;
  logic [31:0]       w_rd_res;
  logic              w_we;

  // Pick the addressed lane and extend according to DMCtrl.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ctrl);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ctrl);
    logic [31:0] res;
    res = word;
    case (ctrl)
      3'b000: res[{off, 3'b000} +: 8] = data[7:0];
      3'b001: begin
        if (off[1]) res[31:16] = data[15:0];
        else        res[15:0]  = data[15:0];
      end
      3'b010:  res = data;
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_accept   = 1'b1;
          w_cnt_next = WS_INIT;
          w_next     = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_exec = (w_next == S_RESP);

  // With zero wait states the access executes on the accept edge, before capture.
  assign w_src_addr  = (r_state == S_IDLE) ? Address : r_addr;
  assign w_src_wdata = (r_state == S_IDLE) ? DataWr  : r_wdata;
  assign w_src_wr    = (r_state == S_IDLE) ? DMWr    : r_wr;
  assign w_src_ctrl  = (r_state == S_IDLE) ? DMCtrl  : r_ctrl;

  assign w_off       = w_src_addr[1:0];
  assign w_word_addr = w_src_addr >> 2;
  assign w_oor       = (w_word_addr >= ADDR_W'(DEPTH_WORDS));
  assign w_ctrl_ok   = (w_src_ctrl == 3'b000) || (w_src_ctrl == 3'b001) ||
                       (w_src_ctrl == 3'b010) || (w_src_ctrl == 3'b100) ||
                       (w_src_ctrl == 3'b101);
  assign w_mis_raw   = ((w_src_ctrl[1:0] == 2'b01) && w_off[0]) ||
                       ((w_src_ctrl == 3'b010) && (w_off != 2'b00));
  assign w_ok        = w_ctrl_ok && !w_oor && !w_mis_raw;

  assign w_idx       = w_src_addr[IDX_W+1:2];
  assign w_cur_word  = r_mem[w_idx];
  assign w_new_word  = store_merge(w_cur_word, w_src_wdata, w_off, w_src_ctrl);
  assign w_rd_res    = (w_ok && !w_src_wr) ? load_extract(w_cur_word, w_off, w_src_ctrl) : 32'd0;
  assign w_we        = w_exec && w_ok && w_src_wr && !w_src_ctrl[2];

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= w_new_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_wr      <= 1'b0;
      r_ctrl    <= 3'd0;
      r_data_rd <= 32'd0;
      r_mis     <= 1'b0;
      r_oor     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= Address;
        r_wdata <= DataWr;
        r_wr    <= DMWr;
        r_ctrl  <= DMCtrl;
      end
      if (w_exec) begin
        r_data_rd <= w_rd_res;
        r_mis     <= w_ctrl_ok && !w_oor && w_mis_raw;
        r_oor     <= w_ctrl_ok && w_oor;
      end
    end
  end

  assign DataRd     = r_data_rd;
  assign Ready      = (r_state == S_RESP);
  assign Busy       = (r_state != S_IDLE);
  assign Misaligned = r_mis;
  assign OutOfRange = r_oor;

endmodule
